// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back stage: destination-file
// encodings, the buffered result record and the scoreboard tag mapping.
package wb_pkg;

  localparam logic [1:0] RW_NONE = 2'b00;
  localparam logic [1:0] RW_GPR  = 2'b01;
  localparam logic [1:0] RW_FPR  = 2'b10;

  localparam int unsigned WB_DATA_W = 32;

  // Default-width result record; the top re-declares it at its own DATA_W.
  typedef struct packed {
    logic [1:0]           rw;
    logic [4:0]           rd;
    logic [WB_DATA_W-1:0] data;
  } wb_req_t;

  // Which source drives the write bus on the next edge.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_ALU,
    SRC_FIFO,
    SRC_LNG
  } wb_src_e;

  // Scoreboard tag: {is_fpr, index}.
  function automatic logic [5:0] tag_of(input logic [1:0] rw, input logic [4:0] rd);
    return {rw == RW_FPR, rd};
  endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Bundle of issue, hazard, result-stream and write-bus signals between the
// pipeline and the write-back unit.
interface writeback_unit_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // Issue and hazard query from decode
  logic              iss_valid;
  logic [1:0]        iss_rw;
  logic [4:0]        iss_rd;
  logic [5:0]        q_rs;
  logic              q_rs_en;
  logic [5:0]        q_rt;
  logic              q_rt_en;
  logic              stall;

  // Single-cycle result stream
  logic              alu_valid;
  logic [1:0]        alu_rw;
  logic [4:0]        alu_rd;
  logic [DATA_W-1:0] alu_data;

  // Multi-cycle result stream
  logic              lng_valid;
  logic              lng_ready;
  logic [1:0]        lng_rw;
  logic [4:0]        lng_rd;
  logic [DATA_W-1:0] lng_data;

  // Register-file write bus
  logic [1:0]        wb_rw;
  logic [4:0]        wb_rd;
  logic [DATA_W-1:0] wb_data;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output iss_valid, iss_rw, iss_rd, q_rs, q_rs_en, q_rt, q_rt_en,
    output alu_valid, alu_rw, alu_rd, alu_data,
    output lng_valid, lng_rw, lng_rd, lng_data,
    input  stall, lng_ready, wb_rw, wb_rd, wb_data, fifo_count
  );

  modport slave (
    input  iss_valid, iss_rw, iss_rd, q_rs, q_rs_en, q_rt, q_rt_en,
    input  alu_valid, alu_rw, alu_rd, alu_data,
    input  lng_valid, lng_rw, lng_rd, lng_data,
    output stall, lng_ready, wb_rw, wb_rd, wb_data, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding long results waiting for a write slot.
// Push and pop may happen together; a full FIFO still accepts a push when
// it pops on the same edge.
module wb_fifo
  import wb_pkg::*;
#(
  parameter type         T     = wb_req_t,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  T                 push_data,
  input  logic             pop,
  output T                 head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  T                 mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy; unchanged when push and pop coincide.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/writeback_unit.sv
// Write-back stage: merges the ALU and long-result streams into one register
// write per cycle, buffers displaced long results, and keeps the busy
// scoreboard that drives the decode stall.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             rstn,
  writeback_unit_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic [1:0]        rw;
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } req_t;

  logic [63:0]      busy;
  logic [63:0]      busy_nxt;
  logic [5:0]       iss_tag;
  logic [5:0]       sel_tag;
  logic             iss_set;
  logic             alu_keep;
  logic             lng_fire;
  logic             lng_keep;
  req_t             alu_req;
  req_t             lng_req;
  req_t             fifo_head;
  req_t             sel;
  req_t             wb_q;
  wb_src_e          src;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  assign alu_req = '{rw: bus.alu_rw, rd: bus.alu_rd, data: bus.alu_data};
  assign lng_req = '{rw: bus.lng_rw, rd: bus.lng_rd, data: bus.lng_data};

  // Ready is based on registered occupancy only, so a full FIFO refuses
  // even on a cycle in which it pops.
  assign lng_fire = bus.lng_valid & ~fifo_full;
  // Results without a destination are accepted but go nowhere.
  assign lng_keep = lng_fire & (bus.lng_rw != RW_NONE);
  assign alu_keep = bus.alu_valid & (bus.alu_rw != RW_NONE);

  assign iss_tag = tag_of(bus.iss_rw, bus.iss_rd);
  assign sel_tag = tag_of(sel.rw, sel.rd);
  // r0 is hardwired, so it never becomes busy.
  assign iss_set = bus.iss_valid & (bus.iss_rw != RW_NONE) & (iss_tag != '0);

  // Hazard: either source pending, or the destination already pending (WAW).
  always_comb begin
    bus.stall = (bus.q_rs_en & busy[bus.q_rs])
              | (bus.q_rt_en & busy[bus.q_rt])
              | ((bus.iss_rw != RW_NONE) & busy[iss_tag]);
  end

  // Fixed-priority source selection: ALU, then queued long, then bypass.
  always_comb begin
    src       = SRC_NONE;
    sel       = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (alu_keep) begin
      src       = SRC_ALU;
      sel       = alu_req;
      fifo_push = lng_keep;
    end else if (!fifo_empty) begin
      src       = SRC_FIFO;
      sel       = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = lng_keep;
    end else if (lng_keep) begin
      src       = SRC_LNG;
      sel       = lng_req;
    end
  end

  // Scoreboard next state; the set is applied last so it wins a collision.
  always_comb begin
    busy_nxt = busy;
    if (src != SRC_NONE) busy_nxt[sel_tag] = 1'b0;
    if (iss_set)         busy_nxt[iss_tag] = 1'b1;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) busy <= '0;
    else       busy <= busy_nxt;
  end

  // Registered write bus; index and data hold when no write is issued.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wb_q <= '0;
    end else if (src != SRC_NONE) begin
      wb_q <= sel;
    end else begin
      wb_q.rw <= RW_NONE;
    end
  end

  wb_fifo #(
    .T     (req_t),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (fifo_push),
    .push_data (lng_req),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.lng_ready  = ~fifo_full;
  assign bus.fifo_count = fifo_count;
  assign bus.wb_rw      = wb_q.rw;
  assign bus.wb_rd      = wb_q.rd;
  assign bus.wb_data    = wb_q.data;

endmodule

// File: tb/tb_writeback_unit.sv
// Testbench for writeback_unit: directed scenarios plus randomized traffic,
// all checked against a queue-based reference model of the write-back rules.
module tb_writeback_unit;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 4;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  writeback_unit_if #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) bus ();

  writeback_unit #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  // Reference model state
  bit   mbusy [64];
  ent_t mq [$];
  ent_t mwb;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tagf(input logic [1:0] rw, input logic [4:0] rd);
    return (rw == 2'b10 ? 32 : 0) + int'(rd);
  endfunction

  function automatic bit m_stall();
    bit s;
    s = 1'b0;
    if (bus.q_rs_en && mbusy[int'(bus.q_rs)]) s = 1'b1;
    if (bus.q_rt_en && mbusy[int'(bus.q_rt)]) s = 1'b1;
    if (bus.iss_rw != 2'b00 && mbusy[tagf(bus.iss_rw, bus.iss_rd)]) s = 1'b1;
    return s;
  endfunction

  task automatic model_reset();
    foreach (mbusy[i]) mbusy[i] = 1'b0;
    mq.delete();
    mwb = '{rw: 2'b00, rd: 5'd0, data: 32'd0};
  endtask

  // One clock edge of the write-back rules.
  task automatic model_edge();
    ent_t a, l, w;
    bit   took, wrote;
    a     = '{rw: bus.alu_rw, rd: bus.alu_rd, data: bus.alu_data};
    l     = '{rw: bus.lng_rw, rd: bus.lng_rd, data: bus.lng_data};
    took  = bus.lng_valid && (mq.size() < DEPTH) && (bus.lng_rw != 2'b00);
    wrote = 1'b1;
    w     = mwb;
    if (bus.alu_valid && bus.alu_rw != 2'b00) begin
      w = a;
      if (took) mq.push_back(l);
    end else if (mq.size() > 0) begin
      w = mq.pop_front();
      if (took) mq.push_back(l);
    end else if (took) begin
      w = l;
    end else begin
      wrote = 1'b0;
      w.rw  = 2'b00;
    end
    if (wrote) mbusy[tagf(w.rw, w.rd)] = 1'b0;
    if (bus.iss_valid && bus.iss_rw != 2'b00 && tagf(bus.iss_rw, bus.iss_rd) != 0)
      mbusy[tagf(bus.iss_rw, bus.iss_rd)] = 1'b1;
    mwb = w;
  endtask

  // Called just after a rising edge with inputs already set.
  task automatic step();
    #1;
    check("stall", 64'(bus.stall), 64'(m_stall()));
    check("lng_ready", 64'(bus.lng_ready), 64'(mq.size() < DEPTH));
    @(posedge clk);
    model_edge();
    #1;
    check("wb_rw", 64'(bus.wb_rw), 64'(mwb.rw));
    if (mwb.rw != 2'b00) begin
      check("wb_rd", 64'(bus.wb_rd), 64'(mwb.rd));
      check("wb_data", 64'(bus.wb_data), 64'(mwb.data));
    end
    check("fifo_count", 64'(bus.fifo_count), 64'(mq.size()));
  endtask

  task automatic clr_in();
    bus.iss_valid = 1'b0; bus.iss_rw = 2'b00; bus.iss_rd = 5'd0;
    bus.q_rs = 6'd0; bus.q_rs_en = 1'b0; bus.q_rt = 6'd0; bus.q_rt_en = 1'b0;
    bus.alu_valid = 1'b0; bus.alu_rw = 2'b00; bus.alu_rd = 5'd0; bus.alu_data = '0;
    bus.lng_valid = 1'b0; bus.lng_rw = 2'b00; bus.lng_rd = 5'd0; bus.lng_data = '0;
  endtask

  task automatic rand_in();
    bus.alu_valid = 1'($urandom_range(0, 1));
    bus.alu_rw    = 2'($urandom_range(0, 2));
    bus.alu_rd    = 5'($urandom_range(0, 7));
    bus.alu_data  = $urandom;
    bus.lng_valid = 1'($urandom_range(0, 1));
    bus.lng_rw    = 2'($urandom_range(0, 2));
    bus.lng_rd    = 5'($urandom_range(0, 7));
    bus.lng_data  = $urandom;
    bus.iss_rw    = 2'($urandom_range(0, 2));
    bus.iss_rd    = 5'($urandom_range(0, 7));
    bus.q_rs      = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))};
    bus.q_rs_en   = 1'($urandom_range(0, 1));
    bus.q_rt      = {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))};
    bus.q_rt_en   = 1'($urandom_range(0, 1));
    bus.iss_valid = 1'b0;
    if (!m_stall()) bus.iss_valid = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int k;
    clr_in();
    model_reset();

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_wb_rw", 64'(bus.wb_rw), 64'(0));
    check("rst_wb_rd", 64'(bus.wb_rd), 64'(0));
    check("rst_wb_data", 64'(bus.wb_data), 64'(0));
    check("rst_lng_ready", 64'(bus.lng_ready), 64'(1));
    check("rst_fifo_count", 64'(bus.fifo_count), 64'(0));
    check("rst_stall", 64'(bus.stall), 64'(0));
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    model_edge();
    #1;

    // Issue GPR r5, then query GPR r5 and FPR f5
    clr_in();
    bus.iss_valid = 1'b1; bus.iss_rw = 2'b01; bus.iss_rd = 5'd5;
    step();
    clr_in();
    bus.q_rs = 6'h05; bus.q_rs_en = 1'b1;
    #1 check("iss_stall_gpr5", 64'(bus.stall), 64'(1));
    bus.q_rs = 6'h25;
    #1 check("iss_stall_fpr5", 64'(bus.stall), 64'(0));

    // ALU result clears busy[5] on the edge that loads wb
    clr_in();
    bus.q_rs = 6'h05; bus.q_rs_en = 1'b1;
    bus.alu_valid = 1'b1; bus.alu_rw = 2'b01; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    step();
    bus.alu_valid = 1'b0;
    check("alu_wb_rw", 64'(bus.wb_rw), 64'(1));
    check("alu_wb_data", 64'(bus.wb_data), 64'h1234);
    #1 check("alu_stall_drop", 64'(bus.stall), 64'(0));

    // ALU / long collision
    clr_in();
    bus.alu_valid = 1'b1; bus.alu_rw = 2'b01; bus.alu_rd = 5'd3; bus.alu_data = 32'hA;
    bus.lng_valid = 1'b1; bus.lng_rw = 2'b10; bus.lng_rd = 5'd7; bus.lng_data = 32'hB;
    step();
    check("col_alu_data", 64'(bus.wb_data), 64'hA);
    check("col_count1", 64'(bus.fifo_count), 64'(1));
    clr_in();
    step();
    check("col_lng_rw", 64'(bus.wb_rw), 64'(2));
    check("col_lng_rd", 64'(bus.wb_rd), 64'(7));
    check("col_lng_data", 64'(bus.wb_data), 64'hB);
    check("col_count0", 64'(bus.fifo_count), 64'(0));

    // Backpressure: ALU holds the bus while long results keep coming
    k = 0;
    for (int i = 0; i < 6; i++) begin
      bit took;
      clr_in();
      bus.alu_valid = 1'b1; bus.alu_rw = 2'b01; bus.alu_rd = 5'(i + 1); bus.alu_data = 32'(i);
      bus.lng_valid = 1'b1; bus.lng_rw = 2'b10; bus.lng_rd = 5'(k); bus.lng_data = 32'(100 + k);
      took = (mq.size() < DEPTH);
      step();
      if (took) k++;
    end
    check("bp_ready_low", 64'(bus.lng_ready), 64'(0));
    check("bp_count_full", 64'(bus.fifo_count), 64'(4));
    clr_in();
    for (int j = 0; j < 4; j++) begin
      step();
      check("bp_order_rw", 64'(bus.wb_rw), 64'(2));
      check("bp_order_data", 64'(bus.wb_data), 64'(100 + j));
    end

    // r0 never busy; rw=00 results are dropped
    clr_in();
    bus.iss_valid = 1'b1; bus.iss_rw = 2'b01; bus.iss_rd = 5'd0;
    step();
    clr_in();
    bus.q_rs = 6'h00; bus.q_rs_en = 1'b1;
    #1 check("r0_stall", 64'(bus.stall), 64'(0));
    bus.alu_valid = 1'b1; bus.alu_rw = 2'b00; bus.alu_rd = 5'd9; bus.alu_data = 32'hDEAD;
    step();
    check("rw00_wb_rw", 64'(bus.wb_rw), 64'(0));
    check("rw00_count", 64'(bus.fifo_count), 64'(0));

    // Mid-operation reset with queued results and a busy FPR
    for (int i = 0; i < 3; i++) begin
      clr_in();
      bus.alu_valid = 1'b1; bus.alu_rw = 2'b01; bus.alu_rd = 5'(i + 1); bus.alu_data = 32'(i);
      bus.lng_valid = 1'b1; bus.lng_rw = 2'b10; bus.lng_rd = 5'(10 + i); bus.lng_data = 32'(200 + i);
      if (i == 0) begin
        bus.iss_rw = 2'b10; bus.iss_rd = 5'd9;
        bus.iss_valid = !m_stall();
      end
      step();
    end
    clr_in();
    bus.q_rs = 6'h29; bus.q_rs_en = 1'b1;
    #1 check("mr_stall_pre", 64'(bus.stall), 64'(1));
    check("mr_count_pre", 64'(bus.fifo_count), 64'(3));
    rstn = 1'b0;
    #1;
    check("mr_count", 64'(bus.fifo_count), 64'(0));
    check("mr_wb_rw", 64'(bus.wb_rw), 64'(0));
    check("mr_stall", 64'(bus.stall), 64'(0));
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mr_no_stale", 64'(bus.wb_rw), 64'(0));
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      rand_in();
      step();
    end

    // Drain
    clr_in();
    repeat (DEPTH + 2) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Write-back stage that produces the register-file write bus consumed by the decode stage: `wb_rw`, `wb_rd` and `wb_data`.
- Merges a single-cycle ALU result stream and a multi-cycle result stream (FPU, memory, IN) into at most one register write per cycle. Long results are buffered in a small FIFO.
- Keeps a 64-entry busy scoreboard (GPR plus FPR), set at issue and cleared at write-back, and gives decode a combinational stall.

Parameters:
- DATA_W, 32, result/data width.
- FIFO_DEPTH, 4, long-result buffer entries; power of two, at least 2.

Ports:
- clk  in  1  clock
- rstn  in  1  reset, asynchronous, active-low
- iss_valid  in  1  decode issues an instruction this cycle (asserted only when stall=0)
- iss_rw  in  2  issued destination file: 00 none, 01 GPR, 10 FPR
- iss_rd  in  5  issued destination index
- q_rs  in  6  source 1 tag, {fpr, idx}
- q_rs_en  in  1  q_rs is used
- q_rt  in  6  source 2 tag
- q_rt_en  in  1  q_rt is used
- stall  out  1  hazard; decode must hold
- alu_valid  in  1  single-cycle result present (no backpressure)
- alu_rw  in  2  its destination file
- alu_rd  in  5  its destination index
- alu_data  in  DATA_W  its result
- lng_valid  in  1  multi-cycle result offered
- lng_ready  out  1  unit can accept a long result
- lng_rw  in  2  long result destination file
- lng_rd  in  5  long result destination index
- lng_data  in  DATA_W  long result
- wb_rw  out  2  register write enable/file to decode
- wb_rd  out  5  register write index
- wb_data  out  DATA_W  register write data
- fifo_count  out  clog2(FIFO_DEPTH)+1  buffered long results

Behaviour:
- Tag encoding: tag = {rw==10, rd}.
- Reset (async, rstn=0):
  - busy = 0 and FIFO empty, so fifo_count = 0 and lng_ready = 1.
  - wb_rw = 00, wb_rd = 0, wb_data = 0.
  - stall is combinational and therefore 0 after reset.
  - A reset mid-operation discards all pending results and busy bits.
- Issue: when iss_valid and iss_rw != 00, busy[tag] is set at the next edge. GPR r0 (tag 0) is never set busy.
- Stall (combinational from registered busy), OR of:
  - q_rs_en & busy[q_rs]
  - q_rt_en & busy[q_rt]
  - (iss_rw != 00) & busy[iss tag], the WAW guard
- Long accept: fire = lng_valid & lng_ready, where lng_ready = (fifo_count < FIFO_DEPTH). lng_ready comes from registered count only, so a full FIFO is not ready even in a cycle when it pops.
- Write-back selection each cycle, fixed priority:
  1. alu_valid with alu_rw != 00 → ALU result. A long fire this cycle is pushed into the FIFO.
  2. else FIFO non-empty → pop the head. A simultaneous long fire is pushed (push and pop together keep the count).
  3. else long fire → bypass directly, no push.
  4. else → wb_rw = 00 for the next cycle.
- Entries with rw = 00 are dropped. They are neither pushed nor written.
- Latency:
  - The selected result appears on wb_* exactly 1 cycle after selection, registered.
  - ALU result: 1 cycle.
  - Long result: 1 cycle when the FIFO is empty and there is no ALU collision, otherwise queued.
- Ordering: long results leave in acceptance order. Bypass happens only when the FIFO is empty.
- Busy clear:
  - On the same edge that loads wb_*, busy[tag of selected result] is cleared.
  - Decode sees busy = 0 while the value is on wb_*; its forwarding covers that cycle.
  - Set and clear of the same tag on one edge is impossible because of stall. If it occurs anyway, set wins.
  - A write-back to a non-busy tag is legal; the clear is then a no-op.
- Overflow: none possible under the handshake. fifo_count saturates at FIFO_DEPTH.
- Pointers wrap modulo FIFO_DEPTH.

Decomposition:
- Package wb_pkg:
  - RW_NONE = 2'b00, RW_GPR = 2'b01, RW_FPR = 2'b10
  - typedef wb_req_t {rw[1:0], rd[4:0], data[DATA_W-1:0]}
  - function tag_of(rw, rd)
- Sub-module wb_fifo: a synchronous FIFO of wb_req_t with push, pop, head, count, full and empty. It must support push and pop in the same cycle and reset asynchronously.
- The top module holds the scoreboard, the priority mux and the output registers.

Test Plan:
- Reset: after rstn release → wb_rw = 00, lng_ready = 1, fifo_count = 0, stall = 0. Then iss_valid with rw = 01, rd = 5 → next cycle q_rs = 6'h05 with q_rs_en gives stall = 1, and q_rs = 6'h25 gives stall = 0.
- ALU path: alu_valid with rw = 01, rd = 5, data = 0x1234 → next cycle wb = {01, 5, 0x1234}. busy[5] clears on that edge, so the stall on q_rs = 5 drops the same cycle wb is valid.
- Collision: the same cycle carries ALU (01, 3, 0xA) and long (10, 7, 0xB) → cycle+1 wb = ALU with fifo_count = 1 → cycle+2 wb = {10, 7, 0xB} with fifo_count = 0.
- Backpressure: hold alu_valid for 6 cycles while offering long every cycle → 4 accepted, then lng_ready = 0. After ALU stops, 4 FPR write-backs follow in order with consecutive data.
- r0 and rw = 00: issue (01, rd = 0) → stall stays 0. An ALU result with rw = 00 → wb_rw stays 00 and the FIFO is unchanged.
- Mid-operation reset: assert rstn = 0 with fifo_count = 3 and busy bits set → immediately fifo_count = 0, wb_rw = 00, stall = 0. No stale write-back follows after release.
